vx_dvg_ctrl: RTL and testbench
==============================

# VX_dvg_ctrl

Warp-side consumer of the divergence protocol. Takes split outcomes from the ALU and join results from the split/join stack unit, and applies them to the per-warp thread masks. Holds each warp's issue lock while a split/join is in flight. Returns else-path PC redirects to the warp scheduler over a valid/ready queue. Sits in the scheduler, between the ALU/split-join outputs and the warp issue logic.

## Interface
- INSTANCE_ID, "", debug tag only
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- lock_valid  in  1  scheduler issued a split/join for lock_wid
- lock_wid  in  NW_WIDTH  warp to lock
- spawn_valid  in  1  warp spawn
- spawn_wid  in  NW_WIDTH  warp being spawned
- spawn_tmask  in  `NUM_THREADS  initial mask for the spawned warp
- split_valid  in  1  split outcome
- split_wid  in  NW_WIDTH  warp of the split
- split_is_dvg  in  1  split diverged
- split_then_tmask  in  `NUM_THREADS  then-path mask
- join_valid  in  1  join result
- join_wid  in  NW_WIDTH  warp of the join
- join_is_dvg  in  1  join popped the stack
- join_is_else  in  1  popped entry is the else path
- join_tmask  in  `NUM_THREADS  popped mask
- join_pc  in  PC_BITS  popped PC
- warp_tmask  out  `NUM_WARPS*`NUM_THREADS  current mask per warp
- warp_locked  out  `NUM_WARPS  warp is barred from issue
- redir_valid  out  1  redirect pending
- redir_ready  in  1  scheduler accepts redirect
- redir_wid  out  NW_WIDTH  redirect warp
- redir_pc  out  PC_BITS  redirect target

## Operation
- Each warp has a state machine with three states: IDLE, LOCKED, REDIR. warp_locked[w] = (state != IDLE).
- lock_valid in IDLE moves the warp to LOCKED. A lock on a non-IDLE warp is ignored and fires an assertion.
- The following apply only in LOCKED; anything else fires an assertion and is ignored.
- Split, split_is_dvg=1: tmask <= split_then_tmask, warp goes to IDLE.
- Split, split_is_dvg=0: tmask unchanged, warp goes to IDLE.
- Join, join_is_dvg=0: warp goes to IDLE.
- Join, join_is_dvg=1, join_is_else=0 (reconvergence): tmask <= join_tmask, warp goes to IDLE.
- Join, join_is_dvg=1, join_is_else=1: tmask <= join_tmask, {join_wid, join_pc} is pushed to the redirect queue, warp goes to REDIR.
- REDIR goes to IDLE on the cycle redir_valid && redir_ready is true for that warp.
- spawn_valid is accepted only in IDLE: tmask <= spawn_tmask. Spawn on a non-IDLE warp fires an assertion.
- Split and join for the same warp in the same cycle is a protocol violation and fires an assertion. In that case join takes priority.
- Events for different warps in the same cycle are all applied.
- A lock and a split/join on the same warp in the same cycle: the split/join is applied and the lock is ignored, with an assertion.
- The redirect queue is FIFO, depth `NUM_WARPS. It cannot overflow because each warp has at most one entry outstanding. Push when full fires an assertion.
- redir_valid must stay high and redir_wid/redir_pc must stay stable until accepted.

## Timing
- Reset values: warp 0 tmask = 1 (thread 0), all other warps = 0; all states IDLE; warp_locked = 0; redir_valid = 0; redir_wid/redir_pc = 0; queue empty.
- Reset asserted mid-operation clears all state immediately. Queued redirects are discarded.
- warp_tmask and warp_locked are registered and update the cycle after the triggering input.
- Redirect latency: a join in cycle N gives redir_valid at N+1 at the earliest.
- A warp unlocks the cycle after the redirect handshake.
- Queue push and pop in the same cycle are both honoured, including when the queue is full (pop frees the slot).
- Throughput: one redirect per cycle.

## Structure
- dvg_redir_t {wid, pc} is added to VX_gpu_pkg. The state enum is local to this block.
- The redirect queue is a VX_fifo_queue instance: DATAW = NW_WIDTH + PC_BITS, DEPTH = `NUM_WARPS.
- Per-warp state and tmask are held in flat register arrays. There is no other sub-module.

## Test plan
All scenarios use NUM_WARPS=4, NUM_THREADS=4.
- Reset → warp_tmask[0]=4'b0001, others 4'b0000; warp_locked=0; redir_valid=0. Reset asserted with one redirect queued → queue empty and redir_valid=0 the same cycle.
- Spawn w2 with tmask 4'b1111, lock w2, split w2 is_dvg=1 then=4'b0011 → next cycle warp_tmask[2]=4'b0011 and warp_locked[2]=0.
- Lock w2, join w2 dvg=1 else=1 tmask=4'b1100 pc=0x80000040 → next cycle tmask=4'b1100, redir_valid=1, redir_wid=2, redir_pc=0x80000040. Hold redir_ready=0 for 3 cycles → outputs stable and warp_locked[2]=1. Raise redir_ready → warp_locked[2]=0 the following cycle.
- Lock w2, join w2 dvg=1 else=0 tmask=4'b1111 → tmask=4'b1111, no redirect, warp unlocked.
- Else-joins on w0..w3 in consecutive cycles with redir_ready=0 → queue full, no drop. Release redir_ready → redirects drain in order 0,1,2,3, one per cycle.
- Join on an IDLE warp, and a double lock on one warp → assertion fires, state unchanged.

Source files
------------

// File: rtl/vx_dvg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vx_dvg_ctrl_pkg
//  Purpose  : Shared sizing constants and redirect record for vx_dvg_ctrl.
//  Revision : 1.0
// ============================================================================
package vx_dvg_ctrl_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int NUM_THREADS = 4;
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int PC_BITS     = 32;

    typedef struct packed {
        logic [NW_WIDTH-1:0] wid;
        logic [PC_BITS-1:0]  pc;
    } dvg_redir_t;

endpackage : vx_dvg_ctrl_pkg
`default_nettype wire

// File: rtl/vx_dvg_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : vx_dvg_ctrl_if
//  Purpose  : Split/join event inputs and redirect return queue.
//  Revision : 1.0
// ============================================================================
interface vx_dvg_ctrl_if;
    import vx_dvg_ctrl_pkg::*;

    logic                   lock_valid;
    logic [NW_WIDTH-1:0]    lock_wid;
    logic                   spawn_valid;
    logic [NW_WIDTH-1:0]    spawn_wid;
    logic [NUM_THREADS-1:0] spawn_tmask;
    logic                   split_valid;
    logic [NW_WIDTH-1:0]    split_wid;
    logic                   split_is_dvg;
    logic [NUM_THREADS-1:0] split_then_tmask;
    logic                   join_valid;
    logic [NW_WIDTH-1:0]    join_wid;
    logic                   join_is_dvg;
    logic                   join_is_else;
    logic [NUM_THREADS-1:0] join_tmask;
    logic [PC_BITS-1:0]     join_pc;
    logic                   redir_valid;
    logic                   redir_ready;
    logic [NW_WIDTH-1:0]    redir_wid;
    logic [PC_BITS-1:0]     redir_pc;

    modport master (
        output lock_valid, lock_wid, spawn_valid, spawn_wid, spawn_tmask,
               split_valid, split_wid, split_is_dvg, split_then_tmask,
               join_valid, join_wid, join_is_dvg, join_is_else, join_tmask, join_pc,
               redir_ready,
        input  redir_valid, redir_wid, redir_pc
    );

    modport slave (
        input  lock_valid, lock_wid, spawn_valid, spawn_wid, spawn_tmask,
               split_valid, split_wid, split_is_dvg, split_then_tmask,
               join_valid, join_wid, join_is_dvg, join_is_else, join_tmask, join_pc,
               redir_ready,
        output redir_valid, redir_wid, redir_pc
    );

endinterface : vx_dvg_ctrl_if
`default_nettype wire

// File: rtl/vx_dvg_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vx_dvg_ctrl_fifo
//  Purpose  : Redirect FIFO; a pop frees the slot for a same-cycle push.
//  Revision : 1.0
// ============================================================================
module vx_dvg_ctrl_fifo #(
    parameter int DATAW = 1,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic [DATAW-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [DATAW-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Forced to zero when empty so the head fields read 0 out of reset.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : vx_dvg_ctrl_fifo
`default_nettype wire

// File: rtl/vx_dvg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vx_dvg_ctrl
//  Purpose  : Applies split/join outcomes to per-warp thread masks and locks.
//  Revision : 1.0
// ============================================================================
module vx_dvg_ctrl
    import vx_dvg_ctrl_pkg::*;
#(
    parameter string INSTANCE_ID = ""
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    vx_dvg_ctrl_if.slave                      dvg_if,
    output logic [NUM_WARPS*NUM_THREADS-1:0]  o_warp_tmask,
    output logic [NUM_WARPS-1:0]              o_warp_locked
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_REDIR  = 2'd2
    } warp_state_e;

    warp_state_e            r_state [NUM_WARPS];
    logic [NUM_THREADS-1:0] r_tmask [NUM_WARPS];

    logic [NUM_WARPS-1:0] w_lock_hit, w_spawn_hit, w_split_hit, w_join_hit, w_pop_hit;
    logic                 w_push, w_pop, w_full, w_empty;
    dvg_redir_t           w_push_data, w_head;

    // Join beats split on the same warp; a split/join beats a lock.
    always_comb begin
        w_lock_hit  = '0;
        w_spawn_hit = '0;
        w_split_hit = '0;
        w_join_hit  = '0;
        w_pop_hit   = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_join_hit[w]  = dvg_if.join_valid  && (dvg_if.join_wid  == NW_WIDTH'(w));
            w_split_hit[w] = dvg_if.split_valid && (dvg_if.split_wid == NW_WIDTH'(w)) && !w_join_hit[w];
            w_lock_hit[w]  = dvg_if.lock_valid  && (dvg_if.lock_wid  == NW_WIDTH'(w))
                             && !w_join_hit[w] && !w_split_hit[w];
            w_spawn_hit[w] = dvg_if.spawn_valid && (dvg_if.spawn_wid == NW_WIDTH'(w));
            w_pop_hit[w]   = w_pop && (w_head.wid == NW_WIDTH'(w));
        end
    end

    assign w_push = dvg_if.join_valid && dvg_if.join_is_dvg && dvg_if.join_is_else
                    && (r_state[dvg_if.join_wid] == ST_LOCKED);
    assign w_pop  = !w_empty && dvg_if.redir_ready;
    assign w_push_data.wid = dvg_if.join_wid;
    assign w_push_data.pc  = dvg_if.join_pc;

    vx_dvg_ctrl_fifo #(
        .DATAW ($bits(dvg_redir_t)),
        .DEPTH (NUM_WARPS)
    ) u_redir_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign dvg_if.redir_valid = !w_empty;
    assign dvg_if.redir_wid   = w_head.wid;
    assign dvg_if.redir_pc    = w_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_state[w] <= ST_IDLE;
                r_tmask[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                case (r_state[w])
                    ST_IDLE: begin
                        if (w_lock_hit[w])  r_state[w] <= ST_LOCKED;
                        if (w_spawn_hit[w]) r_tmask[w] <= dvg_if.spawn_tmask;
                    end
                    ST_LOCKED: begin
                        if (w_join_hit[w]) begin
                            if (dvg_if.join_is_dvg) r_tmask[w] <= dvg_if.join_tmask;
                            r_state[w] <= (dvg_if.join_is_dvg && dvg_if.join_is_else) ? ST_REDIR : ST_IDLE;
                        end else if (w_split_hit[w]) begin
                            if (dvg_if.split_is_dvg) r_tmask[w] <= dvg_if.split_then_tmask;
                            r_state[w] <= ST_IDLE;
                        end
                    end
                    ST_REDIR: begin
                        if (w_pop_hit[w]) r_state[w] <= ST_IDLE;
                    end
                    default: r_state[w] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_warp_tmask  = '0;
        o_warp_locked = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            o_warp_tmask[w*NUM_THREADS +: NUM_THREADS] = r_tmask[w];
            o_warp_locked[w] = (r_state[w] != ST_IDLE);
        end
    end

    // Protocol checks: offending events are dropped by the logic above.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (dvg_if.lock_valid)
                assert (r_state[dvg_if.lock_wid] == ST_IDLE)
                    else $warning("%s: lock on busy warp %0d", INSTANCE_ID, dvg_if.lock_wid);
            if (dvg_if.spawn_valid)
                assert (r_state[dvg_if.spawn_wid] == ST_IDLE)
                    else $warning("%s: spawn on busy warp %0d", INSTANCE_ID, dvg_if.spawn_wid);
            if (dvg_if.split_valid)
                assert (r_state[dvg_if.split_wid] == ST_LOCKED)
                    else $warning("%s: split on unlocked warp %0d", INSTANCE_ID, dvg_if.split_wid);
            if (dvg_if.join_valid)
                assert (r_state[dvg_if.join_wid] == ST_LOCKED)
                    else $warning("%s: join on unlocked warp %0d", INSTANCE_ID, dvg_if.join_wid);
            assert (!(dvg_if.split_valid && dvg_if.join_valid && dvg_if.split_wid == dvg_if.join_wid))
                else $warning("%s: split and join on same warp", INSTANCE_ID);
            assert (!(dvg_if.lock_valid && ((w_split_hit | w_join_hit) != '0)
                      && (w_lock_hit == '0)))
                else $warning("%s: lock collides with split/join", INSTANCE_ID);
            assert (!(w_push && w_full && !w_pop))
                else $warning("%s: redirect push on full queue", INSTANCE_ID);
        end
    end

endmodule : vx_dvg_ctrl
`default_nettype wire

// File: tb/tb_vx_dvg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_dvg_ctrl
//  Purpose  : Directed bench with redirect scoreboard for vx_dvg_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_vx_dvg_ctrl;
    import vx_dvg_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    logic [NUM_WARPS*NUM_THREADS-1:0] warp_tmask;
    logic [NUM_WARPS-1:0]             warp_locked;

    vx_dvg_ctrl_if dvg_if ();

    vx_dvg_ctrl #(.INSTANCE_ID("tb")) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dvg_if        (dvg_if),
        .o_warp_tmask  (warp_tmask),
        .o_warp_locked (warp_locked)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    dvg_redir_t sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted redirect must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && dvg_if.redir_valid && dvg_if.redir_ready) begin
            n_pops++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL redir_unexpected: got wid=%0d pc=0x%0h expected none",
                         dvg_if.redir_wid, dvg_if.redir_pc);
            end else begin
                dvg_redir_t e;
                e = sb.pop_front();
                chk("redir_wid", 64'(dvg_if.redir_wid), 64'(e.wid));
                chk("redir_pc",  64'(dvg_if.redir_pc),  64'(e.pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dvg_if.lock_valid  = 1'b0;
        dvg_if.spawn_valid = 1'b0;
        dvg_if.split_valid = 1'b0;
        dvg_if.join_valid  = 1'b0;
    endtask

    task automatic set_lock(input int w);
        dvg_if.lock_valid = 1'b1;
        dvg_if.lock_wid   = NW_WIDTH'(w);
    endtask

    task automatic set_split(input int w, input logic dvg, input logic [NUM_THREADS-1:0] m);
        dvg_if.split_valid      = 1'b1;
        dvg_if.split_wid        = NW_WIDTH'(w);
        dvg_if.split_is_dvg     = dvg;
        dvg_if.split_then_tmask = m;
    endtask

    task automatic set_join(input int w, input logic dvg, input logic els,
                            input logic [NUM_THREADS-1:0] m, input logic [PC_BITS-1:0] pc,
                            input bit expect_redir);
        dvg_redir_t e;
        dvg_if.join_valid   = 1'b1;
        dvg_if.join_wid     = NW_WIDTH'(w);
        dvg_if.join_is_dvg  = dvg;
        dvg_if.join_is_else = els;
        dvg_if.join_tmask   = m;
        dvg_if.join_pc      = pc;
        if (expect_redir) begin
            e.wid = NW_WIDTH'(w);
            e.pc  = pc;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        tick();
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        dvg_if.lock_wid = '0;  dvg_if.spawn_wid = '0; dvg_if.spawn_tmask = '0;
        dvg_if.split_wid = '0; dvg_if.split_is_dvg = 1'b0; dvg_if.split_then_tmask = '0;
        dvg_if.join_wid = '0;  dvg_if.join_is_dvg = 1'b0;  dvg_if.join_is_else = 1'b0;
        dvg_if.join_tmask = '0; dvg_if.join_pc = '0; dvg_if.redir_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_tmask",  64'(warp_tmask), 64'h0001);
        chk("rst_locked", 64'(warp_locked), 64'h0);
        chk("rst_rvalid", 64'(dvg_if.redir_valid), 64'h0);
        chk("rst_rwid",   64'(dvg_if.redir_wid), 64'h0);
        chk("rst_rpc",    64'(dvg_if.redir_pc), 64'h0);

        // Spawn, lock, divergent split
        dvg_if.spawn_valid = 1'b1; dvg_if.spawn_wid = 2'd2; dvg_if.spawn_tmask = 4'b1111;
        step();
        chk("spawn_tmask", 64'(warp_tmask), 64'h0F01);
        set_lock(2); step();
        chk("lock_locked", 64'(warp_locked), 64'h4);
        set_split(2, 1'b1, 4'b0011); step();
        chk("split_tmask",  64'(warp_tmask), 64'h0301);
        chk("split_locked", 64'(warp_locked), 64'h0);

        // Else join, redirect held back for three cycles
        set_lock(2); step();
        set_join(2, 1'b1, 1'b1, 4'b1100, 32'h8000_0040, 1'b1); step();
        chk("else_tmask",  64'(warp_tmask), 64'h0C01);
        chk("else_rvalid", 64'(dvg_if.redir_valid), 64'h1);
        chk("else_rwid",   64'(dvg_if.redir_wid), 64'h2);
        chk("else_rpc",    64'(dvg_if.redir_pc), 64'h8000_0040);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_rvalid", 64'(dvg_if.redir_valid), 64'h1);
            chk("hold_rwid",   64'(dvg_if.redir_wid), 64'h2);
            chk("hold_rpc",    64'(dvg_if.redir_pc), 64'h8000_0040);
            chk("hold_locked", 64'(warp_locked), 64'h4);
        end
        dvg_if.redir_ready = 1'b1;
        step();
        dvg_if.redir_ready = 1'b0;
        chk("accept_locked", 64'(warp_locked), 64'h0);
        chk("accept_rvalid", 64'(dvg_if.redir_valid), 64'h0);

        // Reconvergence join
        set_lock(2); step();
        set_join(2, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0); step();
        chk("reconv_tmask",  64'(warp_tmask), 64'h0F01);
        chk("reconv_rvalid", 64'(dvg_if.redir_valid), 64'h0);
        chk("reconv_locked", 64'(warp_locked), 64'h0);

        // Fill the redirect queue, then drain it in order
        for (int w = 0; w < 4; w++) begin
            set_lock(w); step();
        end
        chk("fill_lockall", 64'(warp_locked), 64'hF);
        set_join(0, 1'b1, 1'b1, 4'b0001, 32'h100, 1'b1); step();
        set_join(1, 1'b1, 1'b1, 4'b0010, 32'h200, 1'b1); step();
        set_join(2, 1'b1, 1'b1, 4'b0100, 32'h300, 1'b1); step();
        set_join(3, 1'b1, 1'b1, 4'b1000, 32'h400, 1'b1); step();
        step();
        chk("full_tmask",  64'(warp_tmask), 64'h8421);
        chk("full_rvalid", 64'(dvg_if.redir_valid), 64'h1);
        chk("full_rwid",   64'(dvg_if.redir_wid), 64'h0);
        chk("full_locked", 64'(warp_locked), 64'hF);
        n_pops = 0;
        dvg_if.redir_ready = 1'b1;
        step();
        chk("drain1_locked", 64'(warp_locked), 64'hE);
        chk("drain1_rwid",   64'(dvg_if.redir_wid), 64'h1);
        step(); step(); step();
        dvg_if.redir_ready = 1'b0;
        chk("drain_pops",   64'(n_pops), 64'd4);
        chk("drain_rvalid", 64'(dvg_if.redir_valid), 64'h0);
        chk("drain_locked", 64'(warp_locked), 64'h0);
        chk("drain_sb",     64'(sb.size()), 64'd0);

        // Illegal events leave state untouched
        set_join(1, 1'b1, 1'b1, 4'b1111, 32'h999, 1'b0); step();
        chk("idlejoin_tmask",  64'(warp_tmask), 64'h8421);
        chk("idlejoin_rvalid", 64'(dvg_if.redir_valid), 64'h0);
        chk("idlejoin_locked", 64'(warp_locked), 64'h0);
        set_lock(1); step();
        set_lock(1); step();
        chk("dbllock_locked", 64'(warp_locked), 64'h2);
        set_join(1, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0); step();
        chk("nodvg_join_locked", 64'(warp_locked), 64'h0);
        chk("nodvg_join_tmask",  64'(warp_tmask), 64'h8421);

        // Non-divergent split keeps the mask
        set_lock(3); step();
        set_split(3, 1'b0, 4'b0000); step();
        chk("uni_split_tmask",  64'(warp_tmask), 64'h8421);
        chk("uni_split_locked", 64'(warp_locked), 64'h0);

        // Split and join together on one warp: join wins
        set_lock(1); step();
        set_split(1, 1'b1, 4'b0011);
        set_join(1, 1'b1, 1'b0, 4'b0110, 32'h0, 1'b0);
        step();
        chk("prio_tmask",  64'(warp_tmask), 64'h8461);
        chk("prio_locked", 64'(warp_locked), 64'h0);

        // Lock on one warp and split on another in the same cycle
        set_lock(1); step();
        set_lock(0);
        set_split(1, 1'b1, 4'b0001);
        step();
        chk("multi_tmask",  64'(warp_tmask), 64'h8411);
        chk("multi_locked", 64'(warp_locked), 64'h1);
        set_join(0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0); step();
        chk("multi_unlock", 64'(warp_locked), 64'h0);

        // Asynchronous reset with a redirect queued
        set_lock(2); step();
        set_join(2, 1'b1, 1'b1, 4'b0101, 32'h500, 1'b1); step();
        chk("prerst_rvalid", 64'(dvg_if.redir_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_rvalid", 64'(dvg_if.redir_valid), 64'h0);
        chk("midrst_locked", 64'(warp_locked), 64'h0);
        chk("midrst_tmask",  64'(warp_tmask), 64'h0001);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_rvalid", 64'(dvg_if.redir_valid), 64'h0);
        chk("final_sb",       64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vx_dvg_ctrl
`default_nettype wire
